// File: rtl/fifo_sync_ctrl_pkg.sv
// Shared definitions for the synchronous FIFO controller: default sizes,
// depth formula and output-stage state encoding.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEPTH          = 2 ** DEF_ADDR_WIDTH;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_t;

endpackage

// File: rtl/fifo_sync_ctrl_if.sv
// Producer/consumer handshake bundle; signal names are seen from the controller,
// so the controller uses the slave modport and the traffic source uses master.
interface fifo_sync_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  i_wr_valid;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  o_wr_ready;
  logic                  o_rd_valid;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  i_rd_ready;

  modport master (
    output i_wr_valid, i_wr_data, i_rd_ready,
    input  o_wr_ready, o_rd_valid, o_rd_data
  );

  modport slave (
    input  i_wr_valid, i_wr_data, i_rd_ready,
    output o_wr_ready, o_rd_valid, o_rd_data
  );

endinterface

// File: rtl/fifo_sync_ctrl_ptr.sv
// Wrap-bit FIFO pointer: ADDR_WIDTH address bits plus one lap bit, with
// increment and synchronous clear.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clr,
  input  logic                i_inc,
  output logic [ADDR_WIDTH:0] o_ptr
);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      o_ptr <= '0;
    end else if (i_inc) begin
      o_ptr <= o_ptr + (ADDR_WIDTH + 1)'(1);
    end
  end

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller: owns pointers, status and both handshakes,
// plus a one-entry registered output stage fed from the external memory.
module fifo_sync_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AFULL_THR  = 28
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  fifo_sync_ctrl_if.slave       bus,
  output logic                  o_mem_w_inc,
  output logic                  o_mem_w_full,
  output logic [DATA_WIDTH-1:0] o_mem_wr_data,
  output logic [ADDR_WIDTH-1:0] o_mem_wr_addr,
  output logic [ADDR_WIDTH-1:0] o_mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full
);

  localparam logic [ADDR_WIDTH:0] AFULL_VAL = AFULL_THR[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  push;
  logic                  load;
  out_state_t            state_q;
  out_state_t            state_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_flush),
    .i_inc (push),
    .o_ptr (wr_ptr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_flush),
    .i_inc (load),
    .o_ptr (rd_ptr)
  );

  // Status comes only from the registered pointers; the difference of the
  // lap-extended pointers is exactly the number of entries in memory.
  assign o_full        = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                         (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign o_empty       = (wr_ptr == rd_ptr);
  assign o_count       = wr_ptr - rd_ptr;
  assign o_almost_full = (o_count >= AFULL_VAL);

  assign bus.o_wr_ready = ~o_full;
  assign push = bus.i_wr_valid & ~o_full & ~i_flush;
  assign load = ~o_empty & ((state_q == OUT_EMPTY) | bus.i_rd_ready) & ~i_flush;

  assign o_mem_w_inc   = push;
  assign o_mem_w_full  = o_full;
  assign o_mem_wr_data = bus.i_wr_data;
  assign o_mem_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign o_mem_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= OUT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = OUT_EMPTY;
    end else if (load) begin
      state_d = OUT_VALID;
    end else if ((state_q == OUT_VALID) && bus.i_rd_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  always_comb begin
    bus.o_rd_valid = (state_q == OUT_VALID);
  end

  // Flush only invalidates the stage; the payload register is cleared by reset alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_data_q <= '0;
    end else if (load) begin
      rd_data_q <= i_mem_rd_data;
    end
  end

  assign bus.o_rd_data = rd_data_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Scoreboard bench for fifo_sync_ctrl with a behavioural RAM beside the controller.
module tb_fifo_sync_ctrl;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          mem_w_inc;
  logic          mem_w_full;
  logic [DW-1:0] mem_wr_data;
  logic [AW-1:0] mem_wr_addr;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          almost_full;

  logic [DW-1:0] mem_model [2**AW];
  logic [DW-1:0] exp_q [$];
  int            n_checks;
  int            n_pass;

  fifo_sync_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  fifo_sync_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THR(28)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_flush       (flush),
    .bus           (bus.slave),
    .o_mem_w_inc   (mem_w_inc),
    .o_mem_w_full  (mem_w_full),
    .o_mem_wr_data (mem_wr_data),
    .o_mem_wr_addr (mem_wr_addr),
    .o_mem_rd_addr (mem_rd_addr),
    .i_mem_rd_data (mem_rd_data),
    .o_count       (count),
    .o_full        (full),
    .o_empty       (empty),
    .o_almost_full (almost_full)
  );

  always @(posedge clk) begin
    if (mem_w_inc && !mem_w_full) mem_model[mem_wr_addr] <= mem_wr_data;
  end
  assign mem_rd_data = mem_model[mem_rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Consumer-side monitor: every completed read handshake pops the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.o_rd_valid && bus.i_rd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL rd_data: got 0x%0h, expected no entry", bus.o_rd_data);
      end else begin
        check_output("rd_data", bus.o_rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic valid, input logic [DW-1:0] data, input bit expect_accept);
    bus.i_wr_valid = valid;
    bus.i_wr_data  = data;
    if (valid && expect_accept) exp_q.push_back(data);
  endtask

  task automatic drain_all(input int budget);
    bit done;
    done = 1'b0;
    bus.i_rd_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (empty && !bus.o_rd_valid) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check_output("drain_done", done, 1);
    bus.i_rd_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    bus.i_wr_valid = 1'b0;
    bus.i_wr_data  = '0;
    bus.i_rd_ready = 1'b0;

    // Reset
    repeat (2) step();
    rst = 1'b0;
    step();
    check_output("rst_empty", empty, 1);
    check_output("rst_rd_valid", bus.o_rd_valid, 0);
    check_output("rst_count", count, 0);
    check_output("rst_wr_ready", bus.o_wr_ready, 1);
    check_output("rst_full", full, 0);
    check_output("rst_afull", almost_full, 0);
    check_output("rst_rd_data", bus.o_rd_data, 0);
    check_output("rst_w_inc", mem_w_inc, 0);
    check_output("rst_wr_addr", mem_wr_addr, 0);
    check_output("rst_rd_addr", mem_rd_addr, 0);

    // Single write: memory at E0, output stage at E1
    apply_stimulus(1'b1, 8'hA5, 1'b1);
    step();
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("single_count_e0", count, 1);
    check_output("single_valid_e0", bus.o_rd_valid, 0);
    step();
    check_output("single_valid_e1", bus.o_rd_valid, 1);
    check_output("single_data_e1", bus.o_rd_data, 8'hA5);
    check_output("single_count_e1", count, 0);
    bus.i_rd_ready = 1'b1;
    step();
    bus.i_rd_ready = 1'b0;
    check_output("single_valid_after_pop", bus.o_rd_valid, 0);

    // Fill: 33 writes, first one ends up in the output register
    for (int i = 0; i < 33; i++) begin
      check_output("fill_wr_ready", bus.o_wr_ready, 1);
      apply_stimulus(1'b1, DW'(i), 1'b1);
      step();
      check_output("fill_count", count, (i == 0) ? 1 : i);
      check_output("fill_afull", almost_full, (((i == 0) ? 1 : i) >= 28) ? 1 : 0);
    end
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("fill_full", full, 1);
    check_output("fill_wr_ready_low", bus.o_wr_ready, 0);
    check_output("fill_rd_data", bus.o_rd_data, 8'h00);
    apply_stimulus(1'b1, 8'hEE, 1'b0);
    #1;
    check_output("full_w_inc_gated", mem_w_inc, 0);
    step();
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("full_count_hold", count, 32);

    // Drain in order while the read address wraps 31 -> 0
    bus.i_rd_ready = 1'b1;
    for (int k = 0; k < 33; k++) begin
      step();
      if (k < 32) check_output("drain_rd_addr", mem_rd_addr, (3 + k) % 32);
    end
    bus.i_rd_ready = 1'b0;
    check_output("drain_empty", empty, 1);
    check_output("drain_rd_valid", bus.o_rd_valid, 0);

    // Streaming: one push and one pop per cycle
    bus.i_rd_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      apply_stimulus(1'b1, DW'($urandom_range(0, 255)), 1'b1);
      step();
      check_output("stream_count", count, 1);
    end
    apply_stimulus(1'b0, 8'h00, 1'b0);
    drain_all(16);

    // Flush with a same-cycle write that must be dropped
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, DW'(8'h40 + i), 1'b1);
      step();
    end
    flush = 1'b1;
    apply_stimulus(1'b1, 8'h77, 1'b0);
    #1;
    check_output("flush_w_inc_gated", mem_w_inc, 0);
    step();
    flush = 1'b0;
    apply_stimulus(1'b0, 8'h00, 1'b0);
    exp_q.delete();
    check_output("flush_count", count, 0);
    check_output("flush_rd_valid", bus.o_rd_valid, 0);
    check_output("flush_empty", empty, 1);
    check_output("flush_wr_addr", mem_wr_addr, 0);
    check_output("flush_rd_addr", mem_rd_addr, 0);
    repeat (2) step();
    check_output("flush_rd_valid_later", bus.o_rd_valid, 0);
    apply_stimulus(1'b1, 8'h99, 1'b1);
    step();
    apply_stimulus(1'b0, 8'h00, 1'b0);
    drain_all(16);

    // Full with a pop in the same cycle; refill lands at the freed address
    for (int i = 0; i < 33; i++) begin
      apply_stimulus(1'b1, DW'(8'h80 + i), 1'b1);
      step();
    end
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("refill_full", full, 1);
    check_output("refill_rd_addr", mem_rd_addr, 2);
    bus.i_rd_ready = 1'b1;
    #1;
    check_output("pop_cycle_wr_ready", bus.o_wr_ready, 0);
    step();
    bus.i_rd_ready = 1'b0;
    check_output("after_pop_wr_ready", bus.o_wr_ready, 1);
    check_output("after_pop_count", count, 31);
    check_output("after_pop_rd_data", bus.o_rd_data, 8'h81);
    apply_stimulus(1'b1, 8'hC3, 1'b1);
    #1;
    check_output("freed_w_inc", mem_w_inc, 1);
    check_output("freed_wr_addr", mem_wr_addr, 2);
    step();
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("refull_full", full, 1);
    check_output("refull_count", count, 32);
    drain_all(64);

    check_output("scoreboard_leftover", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
